// File: rtl/alu_pipe.sv
// Registered, width-parametrised ALU with valid/ready on both sides.
// Iterative shift-add multiply present only when ALU_PIPE_MUL_EN is defined.
module alu_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [3:0]       Op,
  input  logic             invA,
  input  logic             invB,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Ofl,
  output logic             Z,
  output logic             busy
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = CNTW + 1;

  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [CNTW-1:0]  shAmt;
  logic [WIDTH:0]   addFull;
  logic [WIDTH-1:0] aluRes;
  logic             aluOfl;
  logic             outFree;
  logic             accept;
  logic             isMulOp;
  logic             loadSingle;
  logic             mulLoad;
  logic [WIDTH-1:0] mulRes;
  logic             mulOfl;

  always_comb begin
    opA   = invA ? ~A : A;
    opB   = invB ? ~B : B;
    shAmt = opB[CNTW-1:0];
  end

  // Single-cycle result and overflow
  always_comb begin
    aluRes  = '0;
    aluOfl  = 1'b0;
    addFull = {1'b0, opA} + {1'b0, opB} + (WIDTH+1)'(Cin);
    unique case (Op)
      4'b0000: aluRes = (opA << shAmt) | (opA >> (WIDTH - shAmt));
      4'b0001: aluRes = opA << shAmt;
      4'b0010: aluRes = (opA >> shAmt) | (opA << (WIDTH - shAmt));
      4'b0011: aluRes = opA >> shAmt;
      4'b0100: begin
        aluRes = addFull[WIDTH-1:0];
        aluOfl = sign ? ((opA[WIDTH-1] == opB[WIDTH-1]) &&
                         (addFull[WIDTH-1] != opA[WIDTH-1]))
                      : addFull[WIDTH];
      end
      4'b0101: aluRes = opA | opB;
      4'b0110: aluRes = opA ^ opB;
      4'b0111: aluRes = opA & opB;
      default: begin
        aluRes = '0;
        aluOfl = 1'b0;
      end
    endcase
  end

  always_comb begin
    outFree    = !out_valid || out_ready;
    in_ready   = !busy && outFree;
    accept     = in_valid && in_ready;
    loadSingle = accept && !isMulOp;
  end

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state;
  state_t           stateNext;
  logic [W2-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [W2-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             resNeg;
  logic             mulSigned;
  logic [W2-1:0]    prod;
  logic [WIDTH:0]   prodHi;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic             startMul;

  assign isMulOp  = (Op == 4'b1000);
  assign startMul = accept && isMulOp;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (startMul) stateNext = MUL;
      MUL:     if (cnt == '0) stateNext = DONE;
      DONE:    if (outFree) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    mulLoad = (state == DONE) && outFree;
  end

  // Sign-magnitude operands and final product shaping
  always_comb begin
    magA   = (sign && opA[WIDTH-1]) ? WIDTH'(-opA) : opA;
    magB   = (sign && opB[WIDTH-1]) ? WIDTH'(-opB) : opB;
    prod   = resNeg ? W2'(-acc) : acc;
    prodHi = prod[W2-1:WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      resNeg    <= 1'b0;
      mulSigned <= 1'b0;
      mulRes    <= '0;
      mulOfl    <= 1'b0;
    end else if (state == IDLE && startMul) begin
      mcand     <= {{WIDTH{1'b0}}, magA};
      mplier    <= magB;
      acc       <= '0;
      cnt       <= CW'(WIDTH);
      resNeg    <= sign && (opA[WIDTH-1] ^ opB[WIDTH-1]);
      mulSigned <= sign;
    end else if (state == MUL) begin
      if (cnt != '0) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end else begin
        mulRes <= prod[WIDTH-1:0];
        mulOfl <= mulSigned ? !((prodHi == '0) || (prodHi == '1))
                            : (prod[W2-1:WIDTH] != '0);
      end
    end
  end
`else
  assign isMulOp = 1'b0;
  assign busy    = 1'b0;
  assign mulLoad = 1'b0;
  assign mulRes  = '0;
  assign mulOfl  = 1'b0;
`endif

  // Output registers: load, hold under back-pressure, or retire
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Out       <= '0;
      Ofl       <= 1'b0;
      Z         <= 1'b1;
    end else if (loadSingle) begin
      out_valid <= 1'b1;
      Out       <= aluRes;
      Ofl       <= aluOfl;
      Z         <= (aluRes == '0);
    end else if (mulLoad) begin
      out_valid <= 1'b1;
      Out       <= mulRes;
      Ofl       <= mulOfl;
      Z         <= (mulRes == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=16); multiply checks follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic [3:0]  Op;
  logic        invA;
  logic        invB;
  logic        sign;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Out;
  logic        Ofl;
  logic        Z;
  logic        busy;

  int total = 0;
  int bad   = 0;
  bit randReady = 1'b0;
  logic [16:0] sbq[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Op(Op), .invA(invA), .invB(invB), .sign(sign),
    .out_valid(out_valid), .out_ready(out_ready), .Out(Out), .Ofl(Ofl),
    .Z(Z), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: returns {ofl, out}
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic [3:0] op,
                                        input logic ia, input logic ib, input logic sg);
    logic [15:0] oa, ob, r;
    logic        of;
    int          n, s, ss;
    longint      p;
    oa = ia ? ~a : a;
    ob = ib ? ~b : b;
    n  = int'(ob[3:0]);
    r  = 16'h0;
    of = 1'b0;
    case (op)
      4'd0: begin r = oa; for (int i = 0; i < n; i++) r = {r[14:0], r[15]}; end
      4'd1: r = oa << n;
      4'd2: begin r = oa; for (int i = 0; i < n; i++) r = {r[0], r[15:1]}; end
      4'd3: r = oa >> n;
      4'd4: begin
        s  = int'(oa) + int'(ob) + int'(cin);
        ss = int'($signed(oa)) + int'($signed(ob)) + int'(cin);
        r  = s[15:0];
        of = sg ? (ss > 32767 || ss < -32768) : (s > 65535);
      end
      4'd5: r = oa | ob;
      4'd6: r = oa ^ ob;
      4'd7: r = oa & ob;
`ifdef ALU_PIPE_MUL_EN
      4'd8: begin
        if (sg) begin
          p  = longint'($signed(oa)) * longint'($signed(ob));
          of = (p > 32767 || p < -32768);
        end else begin
          p  = longint'(oa) * longint'(ob);
          of = (p > 65535);
        end
        r = p[15:0];
      end
`endif
      default: begin r = 16'h0; of = 1'b0; end
    endcase
    return {of, r};
  endfunction

  // Present a bundle until accepted; optionally record the expected result
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic [3:0] op, input logic ia, input logic ib,
                      input logic sg, input bit track);
    bit ok = 1'b0;
    A = a; B = b; Cin = cin; Op = op; invA = ia; invB = ib; sign = sg;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        if (track) sbq.push_back(model(a, b, cin, op, ia, ib, sg));
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("accept", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    while ((sbq.size() != 0 || out_valid) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain", 32'(sbq.size()), 32'd0);
  endtask

  // Output monitor: a transfer occurs on the next rising edge
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("out", 32'(Out), 32'(e[15:0]));
        check("ofl", 32'(Ofl), 32'(e[16]));
        check("z",   32'(Z),   32'(e[15:0] == 16'h0));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; Op = '0; invA = 1'b0; invB = 1'b0; sign = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out",   32'(Out),       32'd0);
    check("rst_ofl",   32'(Ofl),       32'd0);
    check("rst_z",     32'(Z),         32'd1);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);

    // Signed add overflow, with explicit latency-1 check
    send(16'h7FFF, 16'h0001, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1);
    check("add_lat", 32'(out_valid), 32'd1);
    check("add_val", 32'(Out), 32'h8000);
    check("add_sofl", 32'(Ofl), 32'd1);
    send(16'h7FFF, 16'h0001, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h0005, 16'h0005, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b1);
    check("sub_z", 32'(Z), 32'd1);
    check("sub_carry", 32'(Ofl), 32'd1);
    for (int i = 0; i < 4; i++) send(16'h8001, 16'h0004, 1'b0, 4'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h8001, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h1234, 16'h00FF, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();

    // Back-pressure: hold, then retire and accept on the same edge
    out_ready = 1'b0;
    send(16'hF0F0, 16'h3C3C, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_hold", 32'(Out), 32'h3030);
      check("bp_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(16'hF0F0, 16'h3C3C, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_newload", 32'(Out), 32'hCCCC);
    check("bp_newvalid", 32'(out_valid), 32'd1);
    drain();

`ifdef ALU_PIPE_MUL_EN
    send(16'h0100, 16'h0100, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mul_busy", 32'(busy), 32'd1);
    check("mul_noready", 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("mul_lat", 32'(cyc), 32'd18);
    check("mul_val", 32'(Out), 32'h0000);
    check("mul_uofl", 32'(Ofl), 32'd1);
    check("mul_idle", 32'(busy), 32'd0);
    send(16'hFFFD, 16'h0007, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Reset five cycles into a multiply discards it
    send(16'h1234, 16'h0056, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_z", 32'(Z), 32'd1);
    check("abort_ready", 32'(in_ready), 32'd1);
    send(16'h0003, 16'h0004, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
    check("abort_add", 32'(Out), 32'h0007);
    drain();
`else
    send(16'h0100, 16'h0100, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("nomul_busy", 32'(busy), 32'd0);
    check("nomul_z", 32'(Z), 32'd1);
    drain();
`endif

    // Random traffic with random back-pressure
    randReady = 1'b1;
    for (int i = 0; i < 60; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom_range(0, 15)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    randReady = 1'b0;
    #1 out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
